// File: rtl/rdcla_pipe_ctrl.sv
// Pipeline sequencer and 2-requester round-robin arbiter for the 8-bit RDCLA adder.
// Optional performance counters are built only when RDCLA_PERF_CNT_EN is defined.
module rdcla_pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  output logic              sel,
  input  logic              flush,
  output logic [STAGES-1:0] en,
  output logic              out_valid,
  output logic              out_id,
  input  logic              out_ready,
  output logic [1:0]        resp,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  generate
    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
      $error("rdcla_pipe_ctrl: STAGES must be in 2..8");
    end
  endgenerate

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_id;
  logic              r_rr;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_ld_v;
  logic [STAGES-1:0] w_ld_id;
  logic              w_take;
  logic              w_any;
  logic              w_winner;
  logic              w_accept;

  // A stage may advance when it is empty or its successor advances, so bubbles collapse.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = ~r_v[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = ~r_v[k] | w_adv[k+1];
    end
  end

  // Arbitration: a lone requester wins outright, a tie goes to the rr pointer.
  always_comb begin
    w_winner = 1'b0;
    case (req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = r_rr;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_take = reset & ~flush & w_adv[0];
  assign w_any  = w_take & (|req);
  assign gnt    = w_any ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
  assign sel    = w_any & w_winner;

  assign w_ld_v[0]  = w_any;
  assign w_ld_id[0] = sel;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_shift
      assign w_ld_v[gi]  = r_v[gi-1];
      assign w_ld_id[gi] = r_id[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v  <= '0;
      r_id <= '0;
      r_rr <= 1'b0;
    end else begin
      if (flush) begin
        r_v  <= '0;
        r_id <= w_ld_id;
      end else begin
        for (int k = 0; k < STAGES; k++) begin
          if (w_adv[k]) begin
            r_v[k]  <= w_ld_v[k];
            r_id[k] <= w_ld_id[k];
          end
        end
      end
      if (w_any) begin
        r_rr <= ~w_winner;
      end
    end
  end

  // Flush loads every register so stale datapath state is overwritten along with the valids.
  assign en = !reset ? '0 : (flush ? '1 : w_adv);

  assign out_valid = r_v[STAGES-1];
  assign out_id    = r_id[STAGES-1];
  assign w_accept  = out_valid & out_ready & ~flush;
  assign resp      = {w_accept & out_id, w_accept & ~out_id};
  assign busy      = |r_v;

`ifdef RDCLA_PERF_CNT_EN
  logic [CNT_W-1:0] r_ops_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ops_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && (r_ops_cnt != {CNT_W{1'b1}})) begin
        r_ops_cnt <= r_ops_cnt + 1'b1;
      end
      if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign ops_cnt   = r_ops_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign ops_cnt   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/rdcla_pipe_ctrl.md
Name: rdcla_pipe_ctrl

Overview:
- Sequencer and 2-requester arbiter for the pipelined 8-bit recursive-doubling carry-lookahead adder.
- Grants one requester per cycle into pipeline stage 0 and tracks valid/owner bits per stage.
- Drives per-stage load enables for the stage registers (operands, carry-status, G/P vector, carry-in), applies output backpressure with bubble collapsing, and returns results to the owning requester.

Parameters:
- STAGES, 4, number of pipeline register stages, including the input stage; legal range 2..8.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  2  request per requester; bit i belongs to requester i.
- gnt  output  2  one-hot grant; a transfer happens when gnt[i]=1.
- sel  output  1  operand-mux select for stage 0: index of the granted requester.
- flush  input  1  synchronous clear of all stage valids.
- en  output  STAGES  load enable for pipeline register k.
- out_valid  output  1  result present in the last stage.
- out_id  output  1  owner of the result in the last stage.
- out_ready  input  1  consumer accepts the result.
- resp  output  2  one-cycle pulse per requester when its result is accepted.
- busy  output  1  any stage valid.
- ops_cnt  output  CNT_W  number of completed operations.
- stall_cnt  output  CNT_W  number of stalled output cycles.

Behaviour:
- State per stage k: v[k] (valid) and id[k] (owner). Round-robin pointer rr (1 bit) marks the requester with priority.
- Reset (reset=0, asynchronous): all v=0, id=0, rr=0, counters=0. Outputs go to gnt=0, en=0, out_valid=0, resp=0, busy=0.
- Advance chain (combinational):
  - adv[S-1] = !v[S-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1] for k < S-1.
  - en[k] = adv[k].
  - Empty stages always load, so bubbles collapse.
- Stage update on each edge where adv[k]=1:
  - k>0: v[k] <= v[k-1] and id[k] <= id[k-1].
  - k=0: v[0] <= |gnt and id[0] <= sel.
  - Where adv[k]=0 the stage holds.
- Arbitration (combinational):
  - No grant when adv[0]=0.
  - When only one req bit is set, that requester wins.
  - When both are set, requester rr wins.
  - sel = winner index; sel=0 when there is no grant.
  - On any grant, rr <= ~winner at the edge. Without a grant, rr holds.
- Output:
  - out_valid = v[S-1] and out_id = id[S-1].
  - resp[i] = out_valid & out_ready & (out_id==i).
- Latency: a request granted in cycle c gives out_valid in cycle c+S when there is no backpressure. Back-to-back grants give throughput of 1 per cycle.
- Backpressure: with out_valid=1 and out_ready=0, a full pipeline freezes with en=0 and gnt=0. Held results are neither lost nor duplicated.
- flush=1 (synchronous):
  - All v <= 0 at the edge and no grant is issued that cycle.
  - en is forced all-ones so the registers clear.
  - resp is suppressed. rr is unchanged.
  - flush overrides simultaneous out_ready.
- Reset asserted mid-operation drops all in-flight operations immediately; no resp is issued for them.
- busy = OR of all v.

Optional Feature:
- Macro: RDCLA_PERF_CNT_EN.
- Defined:
  - ops_cnt increments when out_valid & out_ready & !flush.
  - stall_cnt increments when out_valid & !out_ready.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: ops_cnt and stall_cnt are tied to 0 and no counter flops are built. Ports remain present.

Test Plan:
- Single request, out_ready=1, STAGES=4: req=01 in cycle 0 → gnt=01 and sel=0 in cycle 0; out_valid=1, out_id=0, resp=01 in cycle 4; busy=0 in cycle 5.
- Both requesters held high for 6 cycles, out_ready=1 → gnt alternates 01,10,01,10,01,10; out_id sequence 0,1,0,1,0,1 in cycles 4–9; ops_cnt=6 when the macro is defined.
- Pipeline filled with 4 operations, out_ready=0 for 5 cycles → gnt=0 and en=0000 during the stall; stall_cnt=5; after release, results drain in order with one resp per cycle.
- Bubble collapse: grant in cycle 0, no request in cycle 1, grant in cycle 2, out_ready=0 in cycles 3–5 → both results occupy stages 3 and 2 with no gap; on release, resp fires in consecutive cycles.
- flush asserted while 3 operations are in flight → all v=0 on the next cycle, no resp for any of them, rr unchanged, busy=0.
- reset driven low asynchronously mid-stream, between clock edges → out_valid, busy and gnt drop immediately; counters read 0; after reset returns high, req=11 grants requester 0 first.
